// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int DEF_RES   = 8;
    localparam int DEF_DIV_W = 16;

    // Index width for n entries, never below 1 so a single channel still has a port.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick prescaler: one tick every div_act+1 clocks; div_act reloads only at the period boundary.
module pwm_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             load_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] q_q, q_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;

    assign tick_o = (q_q == div_act_q);

    always_comb begin
        q_d       = tick_o ? '0 : q_q + 1'b1;
        div_act_d = load_i ? div_i : div_act_q;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            q_q       <= '0;
            div_act_q <= '0;
        end else begin
            q_q       <= q_d;
            div_act_q <= div_act_d;
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// N_CH PWM outputs sharing one prescaler and period counter, with double-buffered duties.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int RES   = DEF_RES,
    parameter int DIV_W = DEF_DIV_W,
    parameter int CH_W  = clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [DIV_W-1:0] div_in,
    input  logic             center_mode,
    input  logic [N_CH-1:0]  pol,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [RES:0]     wr_duty,
    output logic [N_CH-1:0]  pwm_o,
    output logic             period_start
);

    localparam logic [RES-1:0] CNT_MAX = '1;

    logic                      tick, bnd;
    logic [RES-1:0]            cnt_q, cnt_d;
    logic                      dir_q, dir_d;   // 1 = counting down
    logic                      mode_q, mode_d;
    logic [N_CH-1:0][RES:0]    sh_q, sh_d, act_q, act_d;
    logic [N_CH-1:0]           raw, pwm_d, pwm_q;
    logic                      ps_q;

    pwm_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_i  (div_in),
        .load_i (bnd),
        .tick_o (tick)
    );

    assign bnd = tick && ((mode_q == MODE_CENTER) ? (cnt_q == '0 && dir_q)
                                                  : (cnt_q == CNT_MAX));

    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (tick) begin
            if (mode_q == MODE_EDGE) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!dir_q) begin
                if (cnt_q == CNT_MAX) begin
                    dir_d = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    dir_d = 1'b0;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
        // A mode switch restarts the waveform from the bottom, counting up.
        if (bnd) begin
            mode_d = center_mode;
            if (center_mode != mode_q) begin
                cnt_d = '0;
                dir_d = 1'b0;
            end
        end
    end

    always_comb begin
        sh_d = sh_q;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en && int'(wr_ch) == i) sh_d[i] = wr_duty;
        end
        act_d = bnd ? sh_q : act_q;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign raw[g]   = ({1'b0, cnt_q} < act_q[g]);
        assign pwm_d[g] = ena ? (raw[g] ^ pol[g]) : pol[g];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            mode_q <= MODE_EDGE;
            sh_q   <= '0;
            act_q  <= '0;
            pwm_q  <= '0;
            ps_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            sh_q   <= sh_d;
            act_q  <= act_d;
            pwm_q  <= pwm_d;
            ps_q   <= bnd;
        end
    end

    assign pwm_o        = pwm_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench: directed scenarios plus random traffic against a tick-position reference model.
module tb_pwm_multi_ch;

    localparam int N   = 4;
    localparam int RES = 8;
    localparam int DW  = 16;
    localparam int CW  = 3;   // wider than needed so out-of-range channel indices are reachable
    localparam int EP  = 1 << RES;
    localparam int CP  = 2 * EP - 2;

    logic          clk = 1'b0;
    logic          rst_n, ena, center_mode, wr_en;
    logic [DW-1:0] div_in;
    logic [N-1:0]  pol;
    logic [CW-1:0] wr_ch;
    logic [RES:0]  wr_duty;
    logic [N-1:0]  pwm_o;
    logic          period_start;

    pwm_multi_ch #(.N_CH(N), .RES(RES), .DIV_W(DW), .CH_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .div_in       (div_in),
        .center_mode  (center_mode),
        .pol          (pol),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .pwm_o        (pwm_o),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: waveform position m_t counts ticks since the last restart;
    // the counter value and the boundary follow from it arithmetically.
    int           m_rem = 0, m_div = 0, m_t = 0;
    bit           m_mode = 0;
    int           m_sh[N];
    int           m_act[N];
    logic [N-1:0] m_pwm = '0;
    bit           m_ps = 0;
    bit           mb;
    int           mc;
    bit           chk_on = 0;

    function automatic int m_cnt();
        int p;
        if (!m_mode) return m_t % EP;
        p = m_t % CP;
        return (p <= EP - 1) ? p : CP - p;
    endfunction

    function automatic bit m_bnd();
        if (m_rem != 0) return 1'b0;
        if (m_mode) return (m_t % CP == 0) && (m_t > 0);
        return (m_t % EP) == EP - 1;
    endfunction

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_rem = 0; m_div = 0; m_t = 0; m_mode = 0; m_pwm = '0; m_ps = 0;
            for (int i = 0; i < N; i++) begin m_sh[i] = 0; m_act[i] = 0; end
        end else begin
            mb = m_bnd();
            mc = m_cnt();
            for (int i = 0; i < N; i++)
                m_pwm[i] = ena ? ((mc < m_act[i]) ^ pol[i]) : pol[i];
            m_ps = mb;
            if (mb) for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
            if (wr_en && wr_ch < N) m_sh[wr_ch] = int'(wr_duty);
            if (mb) begin
                m_div = int'(div_in);
                if (center_mode != m_mode) begin
                    m_t = 0;
                    m_mode = center_mode;
                end else begin
                    m_t++;
                end
                m_rem = m_div;
            end else if (m_rem == 0) begin
                m_t++;
                m_rem = m_div;
            end else begin
                m_rem--;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst_n) begin
            chk("pwm_model", pwm_o, m_pwm);
            chk("ps_model", period_start, m_ps);
        end
    end

    task automatic wr(input int ch, input int d);
        wr_ch = CW'(ch); wr_duty = (RES+1)'(d); wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_ps(input string tag, input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < lim);
        if (period_start !== 1'b1) chk({tag, "_timeout"}, period_start, 1);
    endtask

    task automatic count_hi(input int ch, input int len, output int hi);
        hi = 0;
        repeat (len) begin
            @(negedge clk);
            if (pwm_o[ch]) hi++;
        end
    endtask

    int n, hi, k, r;

    initial begin
        rst_n = 1'b1; ena = 1'b1; center_mode = 1'b0; div_in = '0; pol = '0;
        wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm_o, 0);
        chk("rst_ps", period_start, 0);
        rst_n = 1'b0;
        chk_on = 1'b1;

        // 25% duty on ch0, edge mode, tick every clock
        wr(0, 64);
        wait_ps("first", 600, n);
        count_hi(0, 256, hi);
        chk("edge_hi64", hi, 64);
        chk("edge_ps_end", period_start, 1);
        wait_ps("spacing", 600, n);
        chk("edge_spacing", n, 256);

        // 0% and 100% duties, then polarity inversion
        wr(1, 0);
        wr(2, 256);
        wait_ps("dc", 600, n);
        count_hi(1, 256, hi);
        chk("duty0", hi, 0);
        count_hi(2, 256, hi);
        chk("duty256", hi, 256);
        pol = 4'b0100;
        count_hi(2, 256, hi);
        chk("duty256_inv", hi, 0);
        pol = 4'b0000;

        // write landing exactly on a boundary edge
        k = 0;
        while (!m_bnd() && k < 600) begin @(negedge clk); k++; end
        chk("bnd_found", k < 600, 1);
        wr(0, 200);
        chk("bnd_ps", period_start, 1);
        count_hi(0, 256, hi);
        chk("bnd_old_duty", hi, 64);
        count_hi(0, 256, hi);
        chk("bnd_new_duty", hi, 200);

        // centre-aligned, div 3
        center_mode = 1'b1; div_in = 16'd3;
        wr(0, 128);
        wait_ps("ctr_sw", 600, n);
        wait_ps("ctr_first", 2200, n);
        count_hi(0, 2040, hi);
        chk("ctr_hi", hi, 1020);
        chk("ctr_period", period_start, 1);
        chk("ctr_mid_high", pwm_o[0], 1);

        // back to edge mode; gate outputs mid-period
        center_mode = 1'b0; div_in = '0;
        wait_ps("edge_sw", 2200, n);
        repeat (100) @(negedge clk);
        pol = 4'b0101; ena = 1'b0;
        @(negedge clk);
        chk("ena_off", pwm_o, 4'b0101);
        repeat (50) @(negedge clk);
        ena = 1'b1;
        wait_ps("ena_a", 300, n);
        chk("ena_phase", n, 256 - 100 - 51);
        wait_ps("ena_b", 300, n);
        chk("ena_spacing", n, 256);

        // out-of-range channel writes are ignored
        pol = '0;
        wr(5, 256);
        wr(7, 300);
        wait_ps("oor", 600, n);
        count_hi(3, 256, hi);
        chk("oor_ch3", hi, 0);
        count_hi(1, 256, hi);
        chk("oor_ch1", hi, 0);

        // random traffic
        for (int i = 0; i < 12000; i++) begin
            wr_en = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                wr_ch = CW'($urandom_range(0, 7));
                wr_duty = (RES+1)'($urandom_range(0, 511));
                wr_en = 1'b1;
            end else if (r == 3) pol = N'($urandom);
            else if (r == 4) ena = ~ena;
            else if (r == 5) div_in = DW'($urandom_range(0, 2));
            else if (r == 6 && $urandom_range(0, 9) == 0) center_mode = ~center_mode;
            @(negedge clk);
        end
        wr_en = 1'b0;

        // asynchronous reset while an output is active
        ena = 1'b1; pol = '0; center_mode = 1'b0; div_in = '0;
        wr(2, 256);
        wait_ps("pre_rst", 2200, n);
        @(negedge clk);
        chk("pre_rst_hi", pwm_o[2], 1);
        #2 rst_n = 1'b1;
        #1;
        chk("arst_pwm", pwm_o, 0);
        chk("arst_ps", period_start, 0);
        @(negedge clk);
        rst_n = 1'b0;
        wait_ps("post_rst", 600, n);
        chk("post_rst_period", n, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
- Parametrised successor to the team's single-channel fixed-divider PWM generator.
- Generates N_CH independent PWM outputs that share one prescaler and one period counter.
- Duty registers are double-buffered, so updates land glitch-free at the period boundary.
- Run-time selectable divider, edge- or centre-aligned mode, and per-channel polarity.
- Sits behind the top-level pin wrapper; driven by a simple write port from the control logic.

Parameters:
- N_CH, 4: number of PWM channels (1..8).
- RES, 8: period counter width in bits; period = 2^RES ticks (edge mode).
- DIV_W, 16: prescaler divider width.
- CH_W, 2: channel index width, equal to clog2(N_CH), minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-high.
- ena  in  1  global enable; low forces all outputs to their inactive level.
- div_in  in  DIV_W  prescaler divide value; tick every div_in+1 clocks.
- center_mode  in  1  0 = edge-aligned, 1 = centre-aligned (up/down).
- pol  in  N_CH  per-channel polarity; 1 inverts the output.
- wr_en  in  1  duty write strobe.
- wr_ch  in  CH_W  channel index for the write.
- wr_duty  in  RES+1  duty value for the write.
- pwm_o  out  N_CH  registered PWM outputs.
- period_start  out  1  one-clk pulse when active duties reload.

Behaviour:
- Reset (async, rst_n=1): prescaler=0, period counter=0, direction=up, all shadow and active duties=0, pwm_o=0, period_start=0, div_act=0, mode_act=0.
- Prescaler:
  - Counter q counts 0..div_act.
  - tick=1 in the cycle q==div_act; q then wraps to 0.
  - div_act=0 gives a tick every clock.
- Edge mode:
  - cnt increments on each tick from 0 to 2^RES-1, then wraps to 0.
  - Boundary = tick while cnt==2^RES-1.
- Centre mode:
  - cnt counts up on ticks to 2^RES-1, then down to 0, then up again; no repeated endpoints.
  - Boundary = tick while cnt==0 and direction=down. Period = 2^(RES+1)-2 ticks.
- Boundary actions, registered, on the same clock edge:
  - active_duty[i] <= shadow_duty[i].
  - div_act <= div_in, mode_act <= center_mode.
  - period_start=1 for one clk.
  - A mode change restarts with cnt=0 and direction=up.
- Writes:
  - wr_en=1 with wr_ch<N_CH sets shadow_duty[wr_ch]<=wr_duty.
  - wr_ch>=N_CH is ignored.
  - A write in the same cycle as a boundary lands in the shadow only; it becomes active at the NEXT boundary.
  - Back-to-back writes to the same channel: the last one wins.
- Compare:
  - raw[i] = (cnt < active_duty[i]), computed with a zero-extended cnt of RES+1 bits.
  - duty=0 gives a constant inactive output.
  - duty>=2^RES gives a constant active output (100%).
- Output:
  - pwm_o[i] <= ena ? raw[i]^pol[i] : pol[i].
  - Latency is 1 clk from cnt change to pwm_o.
- ena:
  - Gates outputs only; prescaler and counter keep running, so the phase is preserved.
- pol:
  - Combinational into the output register, not buffered.
- Reset mid-period: all state clears immediately; the first boundary after release occurs after a full period using div_act=0.

Decomposition:
- Package pwm_pkg holds:
  - mode localparams MODE_EDGE=0, MODE_CENTER=1;
  - function clog2;
  - default RES/DIV_W constants.
- One natural sub-module, pwm_prescaler (q counter, div_act register, tick output).
- Channel compare and output logic sit in a generate loop in the top module.

Test Plan:
- Reset, then write ch0 duty=64 (RES=8, div_in=0, edge). After the first boundary, pwm_o[0] is high 64 clks per 256-clk period; period_start pulses every 256 clks.
- Write ch1 duty=0 and ch2 duty=256 -> ch1 constant 0 and ch2 constant 1 after the boundary; pol[2]=1 gives ch2 constant 0.
- Write ch0=200 in the exact boundary cycle -> the following period still uses the previous value; 200 appears one period later, with no partial-period glitch.
- center_mode=1, duty=128, div_in=3:
  - period=510 ticks=2040 clks;
  - high time=255 ticks=1020 clks;
  - high interval centred on cnt=0.
- ena=0 mid-period with pol=4'b0101 -> pwm_o=4'b0101 next clk; ena=1 resumes in phase (period_start spacing unchanged).
- Assert rst_n during the active phase -> pwm_o=0 asynchronously; wr_ch=5 (N_CH=4) writes have no effect on any channel.
